// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, state encoding and helpers for the PS/2
// keyboard front end.
//   PS2_EXT / PS2_REL / PS2_PAUSE : prefix bytes handled by the decoder
//   PS2_PAUSE_SKIP                : bytes following E1 that are dropped
//   PS2_RSP_*                     : keyboard response codes never reported
//   ps2_state_t                   : frame FSM states
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_REL        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Response codes the keyboard sends to the host, not key events.
    localparam logic [7:0] PS2_RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
    localparam logic [7:0] PS2_RSP_ECHO   = 8'hEE;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    function automatic logic is_response_code(input logic [7:0] b);
        return (b == PS2_RSP_BAT_OK) || (b == PS2_RSP_ACK) ||
               (b == PS2_RSP_RESEND) || (b == PS2_RSP_ECHO);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: brings one raw PS/2 line into the clock domain and
// rejects glitches.
//   i_clk    : system clock
//   i_reset  : synchronous, active-high reset
//   i_line   : raw asynchronous line
//   o_level  : filtered level, changes only after FILTER_LEN consecutive
//              synchronised samples at the new level; resets to 1 (idle)
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_level
);

    localparam int                CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // The lines idle high, so the synchroniser and filter reset to 1 to
    // avoid a spurious falling edge right after reset.
    // NOTE: all state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            // Any sample equal to the current level restarts the run, so
            // the count is the length of the current run at the other level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 keyboard deserialiser and scan-code encoder.
//   clk_sys   : system clock
//   reset     : synchronous, active-high reset
//   ps2_clk   : raw PS/2 clock (asynchronous)
//   ps2_data  : raw PS/2 data (asynchronous)
//   ps2_key   : {toggle, pressed, extended, scan[7:0]}; toggle flips per event
//   frame_err : one-cycle pulse on start/parity/stop error or frame timeout
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 24000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;

    ps2_state_t       r_state;
    ps2_state_t       w_state_next;
    logic             r_clk_prev;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_sh;
    logic             r_par_ok;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic w_start;
    logic w_shift;
    logic w_par_latch;
    logic w_byte_valid;
    logic w_frame_err;

    logic       r_ext;
    logic       r_rel;
    logic [2:0] r_skip;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk   (clk_sys),
        .i_reset (reset),
        .i_line  (ps2_clk),
        .o_level (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .i_clk   (clk_sys),
        .i_reset (reset),
        .i_line  (ps2_data),
        .o_level (w_data_f)
    );

    assign w_fall = r_clk_prev & ~w_clk_f;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_par_latch  = 1'b0;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (w_data_f) begin
                        w_frame_err = 1'b1;
                    end else begin
                        w_start      = 1'b1;
                        w_state_next = DATA;
                    end
                end
                DATA: begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
                PARITY: begin
                    w_par_latch  = 1'b1;
                    w_state_next = STOP;
                end
                STOP: begin
                    if (w_data_f && r_par_ok) begin
                        w_byte_valid = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                    w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end else if (r_state != IDLE && r_tmo_cnt == TMO_LAST) begin
            // A falling edge in the same cycle takes the branch above, so
            // the frame survives a coincident timeout.
            w_frame_err  = 1'b1;
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
            r_bit_cnt  <= '0;
            r_sh       <= '0;
            r_par_ok   <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            r_clk_prev <= w_clk_f;
            if (w_start) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            // LSB arrives first, so shifting right leaves bit 0 in r_sh[0].
            if (w_shift) begin
                r_sh <= {w_data_f, r_sh[7:1]};
            end
            if (w_par_latch) begin
                r_par_ok <= ^{r_sh, w_data_f};
            end
            if (r_state == IDLE || w_fall) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != TMO_MAX) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    // Byte decoder: the completed byte is still held in r_sh while in STOP,
    // so the event word is written on the same edge that ends the frame.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ps2_key   <= '0;
            frame_err <= 1'b0;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_skip    <= '0;
        end else begin
            frame_err <= w_frame_err;
            if (w_frame_err) begin
                r_ext  <= 1'b0;
                r_rel  <= 1'b0;
                r_skip <= '0;
            end else if (w_byte_valid) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 1'b1;
                end else if (r_sh == PS2_PAUSE) begin
                    r_skip <= PS2_PAUSE_SKIP;
                end else if (r_sh == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_sh == PS2_REL) begin
                    r_rel <= 1'b1;
                end else if (is_response_code(r_sh) && !r_ext && !r_rel) begin
                    // Keyboard housekeeping reply; not a key event.
                end else begin
                    ps2_key <= {~ps2_key[10], ~r_rel, r_ext, r_sh};
                    r_ext   <= 1'b0;
                    r_rel   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed bench for ps2_key_encoder. Expected event
// words and error pulses, with the cycle they must appear in, are queued
// when the stimulus drives the relevant clock fall; a monitor pops and
// compares them whenever an output changes.
module tb_ps2_key_encoder;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 300;
    localparam int HALF       = 20;
    // Pin fall -> output: 2 sync + FILTER_LEN filter + 1 edge detect/register.
    localparam int LAT        = FILTER_LEN + 3;

    typedef struct {
        logic [10:0] word;
        int          cyc;
    } key_exp_t;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int          n_total   = 0;
    int          n_bad     = 0;
    int          cyc       = 0;
    int          last_fall = 0;
    key_exp_t    key_q[$];
    int          err_q[$];
    key_exp_t    mon_key;
    int          mon_err;
    logic [10:0] prev_key  = '0;

    ps2_key_encoder #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every change of ps2_key and every frame_err cycle must match
    // the head of its queue, both in value and in arrival cycle.
    always @(negedge clk_sys) begin
        if (reset) begin
            prev_key = ps2_key;
        end else begin
            if (ps2_key !== prev_key) begin
                if (key_q.size() == 0) begin
                    check("key_unexpected", 32'(ps2_key), 32'(prev_key));
                end else begin
                    mon_key = key_q.pop_front();
                    check("key_word", 32'(ps2_key), 32'(mon_key.word));
                    check("key_cycle", 32'(cyc), 32'(mon_key.cyc));
                end
                prev_key = ps2_key;
            end
            if (frame_err !== 1'b0) begin
                if (err_q.size() == 0) begin
                    check("err_unexpected", 32'(frame_err), 32'd0);
                end else begin
                    mon_err = err_q.pop_front();
                    check("err_cycle", 32'(cyc), 32'(mon_err));
                end
            end
        end
    end

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par);
        // stop, odd parity, data LSB first, start
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits,
                             input bit exp_key, input logic [10:0] key,
                             input bit exp_err);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            if (i == 10) begin
                if (exp_key) key_q.push_back('{word: key, cyc: cyc + LAT});
                if (exp_err) err_q.push_back(cyc + LAT);
            end
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_key, input logic [10:0] key);
        send_bits(frame_bits(b, 1'b0), 11, exp_key, key, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_key", 32'(ps2_key), 32'h000);
        check("rst_err", 32'(frame_err), 32'd0);
    endtask

    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        repeat (5) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("init_key", 32'(ps2_key), 32'h000);
        check("init_err", 32'(frame_err), 32'd0);

        // Make, break, extended make, extended break.
        send_byte(8'h29, 1'b1, 11'h629);
        send_byte(8'hF0, 1'b0, 11'h000);
        check("f0_hold", 32'(ps2_key), 32'h629);
        send_byte(8'h29, 1'b1, 11'h029);
        send_byte(8'hE0, 1'b0, 11'h000);
        send_byte(8'h75, 1'b1, 11'h775);
        send_byte(8'hE0, 1'b0, 11'h000);
        send_byte(8'hF0, 1'b0, 11'h000);
        send_byte(8'h75, 1'b1, 11'h175);

        // Parity error: no event, one error pulse; next clean byte normal.
        send_bits(frame_bits(8'h29, 1'b1), 11, 1'b0, 11'h000, 1'b1);
        check("par_hold", 32'(ps2_key), 32'h175);
        send_byte(8'h1C, 1'b1, 11'h61C);

        // Timeout after start + 4 data bits.
        do_reset();
        send_bits(frame_bits(8'h29, 1'b0), 5, 1'b0, 11'h000, 1'b0);
        err_q.push_back(last_fall + LAT + TIMEOUT);
        repeat (TIMEOUT + 50) @(negedge clk_sys);
        send_byte(8'h16, 1'b1, 11'h616);

        // Pause sequence swallowed entirely.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_byte(pause_seq[i], 1'b0, 11'h000);
        end
        send_byte(8'h05, 1'b1, 11'h605);

        // Reset in the middle of the data bits, then a clean frame.
        send_bits(frame_bits(8'h29, 1'b0), 5, 1'b0, 11'h000, 1'b0);
        do_reset();
        send_byte(8'h29, 1'b1, 11'h629);

        repeat (50) @(negedge clk_sys);
        check("key_q_drained", 32'(key_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
